// File: rtl/wind_input_cond.sv
// Input conditioning for the wind-direction landing-light FSM: two-flop sync,
// debouncer, illegal-code filter and a step-rate divider pacing the downstream FSM.
module wind_input_cond #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] dir,
  output logic       step,
  output logic       illegal
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST    = TW'(TICK_DIV - 1);
  localparam logic [1:0]    CODE_ILLEGAL = 2'b11;

  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_s2_prev;
  logic [1:0]    r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_illegal;
  logic [TW-1:0] r_tcnt;
  logic [1:0]    r_dir;
  logic          r_step;
  logic          w_tick;

  assign w_tick = (r_tcnt == TCNT_LAST);

  // NOTE: non-blocking assignments make every flop sample pre-edge values;
  // blocking ones here would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s2_prev <= '0;
    end else begin
      r_s1      <= sw_raw;
      r_s2      <= r_s1;
      r_s2_prev <= r_s2;
    end
  end

  // A code is accepted only after it has been seen unchanged at s2 for
  // DEBOUNCE_CYCLES+1 consecutive evaluations; any change restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable  <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else if (r_s2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_s2 != r_s2_prev) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable  <= r_s2;
      r_illegal <= (r_s2 == CODE_ILLEGAL);
      r_cnt     <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // dir only moves on step edges and samples the pre-edge stable code, so a
  // simultaneous debounce update is delivered one step later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
      r_step <= 1'b0;
      r_dir  <= '0;
    end else begin
      r_tcnt <= w_tick ? '0 : r_tcnt + TW'(1);
      r_step <= w_tick;
      if (w_tick && (r_stable != CODE_ILLEGAL)) begin
        r_dir <= r_stable;
      end
    end
  end

  assign dir     = r_dir;
  assign step    = r_step;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_wind_input_cond.sv
// Self-checking bench for wind_input_cond: a sliding-window reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_wind_input_cond;

  localparam int D  = 4;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sw_raw;
  logic [1:0] dir;
  logic       step;
  logic       illegal;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;

  wind_input_cond #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .dir     (dir),
    .step    (step),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: raw samples per edge; a code is debounced once the
  // 2-edge-delayed raw stream has shown it for D+1 consecutive edges.
  logic [1:0] win [0:D+2];
  logic [1:0] m_stable;
  logic [1:0] m_dir;
  logic       m_step;
  int         m_n;
  bit         m_valid = 1'b0;
  bit         m_run;

  always begin
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i <= D + 2; i++) win[i] = 2'b00;
      m_stable = 2'b00;
      m_dir    = 2'b00;
      m_step   = 1'b0;
      m_n      = 0;
      m_valid  = 1'b1;
    end else begin
      m_n++;
      m_step = (m_n % TD == 0);
      if (m_step && m_stable != 2'b11) m_dir = m_stable;
      for (int i = D + 2; i > 0; i--) win[i] = win[i-1];
      win[0] = sw_raw;
      m_run = 1'b1;
      for (int i = 3; i <= D + 2; i++) if (win[i] != win[2]) m_run = 1'b0;
      if (m_run && win[2] != m_stable) m_stable = win[2];
    end
    #1;
    if (m_valid) begin
      check("model_dir", dir, m_dir);
      check("model_step", step, m_step);
      check("model_illegal", illegal, m_stable == 2'b11);
    end
  end

  task automatic adv_to(input int t);
    while (e < t) begin
      @(negedge clk);
      e++;
    end
  endtask

  initial begin
    reset  = 1'b1;
    sw_raw = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_dir", dir, 2'b00);
    check("rst_step", step, 1'b0);
    check("rst_illegal", illegal, 1'b0);

    // step only after edges 8, 16, 24
    for (int i = 1; i <= 24; i++) begin
      adv_to(i);
      check("step_period", step, (i % 8 == 0));
    end

    // clean change 00 -> 01, E1 = edge 25, stable at edge 31, dir at step edge 32
    sw_raw = 2'b01;
    adv_to(30);
    check("clean_stable_e30", dut.r_stable, 2'b00);
    adv_to(31);
    check("clean_stable_e31", dut.r_stable, 2'b01);
    check("clean_dir_e31", dir, 2'b00);
    adv_to(32);
    check("clean_dir_e32", dir, 2'b01);
    check("clean_step_e32", step, 1'b1);

    // back to 00 baseline
    sw_raw = 2'b00;
    adv_to(40);
    check("base_dir_e40", dir, 2'b00);

    // 3-cycle glitch is rejected
    sw_raw = 2'b10;
    adv_to(43);
    sw_raw = 2'b00;
    for (int i = 44; i <= 59; i++) begin
      adv_to(i);
      check("glitch3_dir", dir, 2'b00);
      check("glitch3_illegal", illegal, 1'b0);
    end

    // 5-cycle pulse accepted at edge 67, released at edge 72 coincident with a step
    adv_to(60);
    sw_raw = 2'b10;
    adv_to(65);
    sw_raw = 2'b00;
    adv_to(67);
    check("pulse5_stable_e67", dut.r_stable, 2'b10);
    adv_to(71);
    check("pulse5_dir_e71", dir, 2'b00);
    adv_to(72);
    check("coincide_stable_e72", dut.r_stable, 2'b00);
    check("coincide_dir_old", dir, 2'b10);
    check("coincide_step", step, 1'b1);
    adv_to(80);
    check("coincide_dir_new", dir, 2'b00);

    // illegal code with dir = 01
    sw_raw = 2'b01;
    adv_to(88);
    check("ill_pre_dir", dir, 2'b01);
    sw_raw = 2'b11;
    adv_to(94);
    check("ill_e6", illegal, 1'b0);
    adv_to(95);
    check("ill_e7", illegal, 1'b1);
    adv_to(112);
    check("ill_dir_hold", dir, 2'b01);
    check("ill_step_e112", step, 1'b1);
    sw_raw = 2'b10;
    adv_to(118);
    check("ill_clear_e6", illegal, 1'b1);
    adv_to(119);
    check("ill_clear_e7", illegal, 1'b0);
    check("ill_clear_dir_e119", dir, 2'b01);
    adv_to(120);
    check("ill_clear_dir_e120", dir, 2'b10);

    // raw returns to stable mid-count: count clears, stable unchanged
    sw_raw = 2'b01;
    adv_to(124);
    sw_raw = 2'b10;
    adv_to(126);
    check("midcnt_cnt_e126", dut.r_cnt, 3);
    adv_to(127);
    check("midcnt_cnt_e127", dut.r_cnt, 0);
    check("midcnt_stable", dut.r_stable, 2'b10);
    adv_to(128);
    check("midcnt_dir", dir, 2'b10);

    // reset mid-operation: tcnt = 5, debounce count = 2
    sw_raw = 2'b01;
    adv_to(133);
    check("midrst_tcnt", dut.r_tcnt, 5);
    check("midrst_cnt", dut.r_cnt, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_dir", dir, 2'b00);
    check("midrst_step", step, 1'b0);
    check("midrst_illegal", illegal, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("midrst_step_period", step, (i == 8));
    end
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wind_input_cond.md
# wind_input_cond

Upstream conditioning stage for the wind-direction landing-light FSM. It takes the two raw wind switches and produces a clean, glitch-free `dir` code plus a one-cycle `step` strobe that paces the downstream FSM. Conditioning consists of a two-flop synchronizer, a debouncer, filtering of the illegal code 2'b11, and a step-rate divider. `dir` changes only on `step` cycles, so the downstream FSM sees a constant code between advances.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a new switch code; legal range ≥1.
- TICK_DIV, 8: clock cycles per `step` pulse; legal range ≥2.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- sw_raw  input  2  asynchronous raw switches; 00 CALM, 01 RTL, 10 LTR, 11 illegal.
- dir  output  2  registered conditioned direction for the downstream FSM.
- step  output  1  registered one-cycle strobe; downstream advances state when high.
- illegal  output  1  high while the debounced switch code is 11.

## Operation
- Synchronizer:
  - `s1 <= sw_raw`, `s2 <= s1`, `s2_prev <= s2`.
  - All three registers reset to 00.
- Debouncer: registers `stable[1:0]` (reset 00) and `cnt` (width clog2(DEBOUNCE_CYCLES)+1, reset 0). At each edge, in priority order:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `s2 != s2_prev`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- Glitch handling:
  - A raw pulse shorter than DEBOUNCE_CYCLES+1 cycles never reaches `stable`.
  - A return to the current `stable` value clears `cnt`.
- Illegal filter:
  - `illegal = (stable == 2'b11)`, driven from a register.
  - `dir` never takes the value 11.
- Step divider: `tcnt` runs 0..TICK_DIV-1 (reset 0), increments every cycle and wraps to 0.
  - At the edge where `tcnt == TICK_DIV-1`: `step <= 1`. If `stable != 11`, `dir <= stable`; otherwise `dir` holds its previous value.
  - At all other edges: `step <= 0` and `dir` holds.
- Simultaneous events: when `stable` updates on the same edge as a step, the step samples the old `stable`. The new value is delivered at the next step.
- Reset mid-operation clears every register in the same edge, whatever the state of the debounce and divider counters.

## Timing
- Reset values: dir=00, step=0, illegal=0, stable=00, all counters 0.
- First `step` is high in the cycle after the TICK_DIV-th edge following reset deassertion.
- `step` period is exactly TICK_DIV cycles and its width is exactly 1 cycle.
- Debounce latency: with `sw_raw` changed before edge E1 and held, `stable` (and `illegal`) update at edge E(DEBOUNCE_CYCLES+3).
- `dir` latency: `dir` takes the new value at the first step edge strictly after the edge at which `stable` updated. Worst case is DEBOUNCE_CYCLES+3+TICK_DIV edges.
- `dir` and `step` change on the same edge, so the downstream FSM samples a valid `dir` whenever `step` is high.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TICK_DIV=8.
- Reset with sw_raw=00:
  - dir=00, step=0, illegal=0 after the reset edge.
  - step high only in the cycles after the 8th, 16th and 24th post-reset edges.
- Clean change: sw_raw 00→01 held, change applied before edge E1.
  - `stable`=01 after E7.
  - dir=01 from the first step edge after E7; step still strictly periodic.
- Glitch rejection, sw_raw=00 baseline:
  - sw_raw=10 for 3 cycles, then 00: dir stays 00 and illegal stays 0 throughout.
  - sw_raw=10 for 5 cycles: accepted; dir=10 at the next step edge.
- Illegal code: with dir=01, drive sw_raw=11 and hold.
  - illegal=1 from the 7th edge after the change.
  - dir holds 01 across at least 3 step pulses.
  - Then sw_raw=10: illegal=0 after 7 edges; dir=10 at the next step edge.
- Boundary:
  - `stable` updates on the same edge as a step: that step outputs the old code; the next step outputs the new code.
  - Raw value returns to `stable` mid-count: `cnt` clears to 0 and `stable` does not change.
- Reset mid-operation: with dir=10, tcnt=5 and a debounce count in progress, pulse reset for 1 cycle.
  - dir=00, step=0, illegal=0 after that edge.
  - Next step follows exactly 8 edges after reset deasserts.
